shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares a single 32-bit logical/arithmetic shifter between two requesters: port 0 is the EX-stage ALU and port 1 is the secondary shift client (load/store byte-lane alignment).
- Arbitration is round-robin, each request port has a valid/ready handshake, and the result passes through one registered output stage with backpressure.
- The block sits beside the EX stage. The pipeline has no forwarding, so it stalls on port-0 ready low.

Parameters:
- NREQ, 2, number of requesters; fixed at 2 for this revision.
- XLEN, 32, data width; shift amount width is log2(XLEN) = 5.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- req_valid_i  in  2  per-port request valid.
- req_ready_o  out  2  per-port request accepted this cycle.
- req_op_i  in  4  two bits per port: 00 SLL, 01 SRL, 10 SRA, 11 illegal.
- req_data_i  in  64  32-bit operand per port; port 0 in [31:0].
- req_shamt_i  in  10  5-bit shift amount per port.
- rsp_valid_o  out  1  result register holds a valid result.
- rsp_ready_i  in  1  consumer accepts the result.
- rsp_data_o  out  32  shifted result.
- rsp_id_o  out  1  index of the port that issued the result.
- rsp_err_o  out  1  the result came from an illegal op.

Behaviour:
- Reset, asynchronous on rst_ni low:
  - rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, rsp_err_o=0.
  - Priority pointer = port 0.
  - req_ready_o is combinationally 0 while rst_ni is low.
- Output slot:
  - The slot is free when rsp_valid_o=0, or when rsp_valid_o=1 and rsp_ready_i=1 in the same cycle (pass-through drain).
  - While the slot is not free, req_ready_o=00.
- Arbitration is combinational within the cycle:
  - Only valid ports compete.
  - If exactly one port is valid, that port wins.
  - If both are valid, the port equal to the priority pointer wins.
  - At most one bit of req_ready_o is high, and only when the slot is free.
- Handshake: a transfer happens when req_valid_i[k] and req_ready_o[k] are both high. The requester must hold op, data and shamt stable until the transfer.
- Pointer update: on every transfer, the priority pointer moves to the other port (winner+1 mod 2). With no transfer it holds.
- Latency: exactly one cycle. A request accepted at edge N sets rsp_valid_o=1 after edge N, with data, id and err registered at that edge.
- Result holds: rsp_data_o, rsp_id_o and rsp_err_o stay stable while rsp_valid_o=1 and rsp_ready_i=0.
- Clearing: if rsp_ready_i=1 and no new transfer happens, rsp_valid_o clears at the next edge. rsp_data_o then holds its last value.
- Shift function:
  - SLL: data << shamt, zero-filled.
  - SRL: data >> shamt, zero-filled.
  - SRA: data >> shamt, filled with data[31].
  - shamt=0 returns the operand unchanged for all three ops.
  - shamt=31 with SRL leaves only bit 0 = data[31].
- Illegal op (11): the request is still accepted and consumes a slot. rsp_data_o=0 and rsp_err_o=1.
- Simultaneous drain and grant: the new result overwrites the register in the same edge and rsp_valid_o stays 1 with no bubble.
- Reset mid-operation: any pending result is discarded and the pointer returns to 0. There is no other internal state.
- No combinational path from req_*_i to rsp_*_o. A path from rsp_ready_i to req_ready_o is permitted.

Test Plan:
- Reset, then single requests:
  - Port 0: SRL, data=0x8000_0000, shamt=31, rsp_ready=1. Expect ready[0]=1 in the cycle, next cycle rsp_valid=1, data=0x0000_0001, id=0, err=0.
  - Port 1: SRA, data=0x8000_0000, shamt=4. Expect rsp_data=0xF800_0000, id=1.
- Contention, both ports continuously valid, rsp_ready=1:
  - Grants alternate 0,1,0,1 starting with port 0 after reset.
  - One result per cycle, no bubbles.
  - rsp_id sequence 0,1,0,1.
- Backpressure:
  - Hold rsp_ready=0 for 3 cycles with both ports valid. Expect req_ready=00 and rsp_data/id stable for all 3 cycles.
  - Raise rsp_ready. Expect a grant in that same cycle and a new result on the next edge.
- Boundaries:
  - SLL data=0xFFFF_FFFF shamt=0 gives 0xFFFF_FFFF.
  - SLL data=0x0000_0001 shamt=31 gives 0x8000_0000.
  - SRA data=0x7FFF_FFFF shamt=31 gives 0x0000_0000.
- Illegal op: port 0 issues op=11, data=0x1234_5678. Expect the handshake to complete, then rsp_err=1 and rsp_data=0. The pointer advances so port 1 wins the next tie.
- Reset mid-operation: assert rst_ni=0 while rsp_valid=1 and rsp_ready=0.
  - rsp_valid drops immediately, without waiting for a clock edge.
  - After release with both ports valid, port 0 is granted first.

Source files
------------

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one shifter between two requesters
// Single registered result stage; a drain and a new grant may share the same edge.
module shift_arbiter #(
   parameter int NREQ = 2,
   parameter int XLEN = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NREQ-1:0]          req_valid_i,
   output logic [NREQ-1:0]          req_ready_o,
   input  logic [2*NREQ-1:0]        req_op_i,
   input  logic [NREQ*XLEN-1:0]     req_data_i,
   input  logic [NREQ*$clog2(XLEN)-1:0] req_shamt_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [XLEN-1:0]          rsp_data_o,
   output logic                     rsp_id_o,
   output logic                     rsp_err_o
);
   localparam int SHW = $clog2(XLEN);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   logic            r_valid;
   logic [XLEN-1:0] r_data;
   logic            r_id;
   logic            r_err;
   logic            r_ptr;

   logic            w_slot_free;
   logic [1:0]      w_grant;
   logic            w_xfer;
   logic            w_sel;
   logic [1:0]      w_op;
   logic [XLEN-1:0] w_data;
   logic [SHW-1:0]  w_shamt;
   logic [XLEN-1:0] w_result;
   logic            w_illegal;

   assign w_slot_free = ~r_valid | rsp_ready_i;

   always_comb begin
      w_grant = 2'b00;
      case (req_valid_i)
         2'b01:   w_grant = 2'b01;
         2'b10:   w_grant = 2'b10;
         2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
         default: w_grant = 2'b00;
      endcase
   end

   // Gate with rst_ni so ready is low during reset without waiting for an edge.
   assign req_ready_o = (rst_ni && w_slot_free) ? w_grant : 2'b00;
   assign w_xfer      = |req_ready_o;
   assign w_sel       = req_ready_o[1];

   assign w_op    = w_sel ? req_op_i[3:2]                  : req_op_i[1:0];
   assign w_data  = w_sel ? req_data_i[2*XLEN-1:XLEN]      : req_data_i[XLEN-1:0];
   assign w_shamt = w_sel ? req_shamt_i[2*SHW-1:SHW]       : req_shamt_i[SHW-1:0];

   always_comb begin
      w_result  = '0;
      w_illegal = 1'b0;
      case (w_op)
         OP_SLL:  w_result = w_data << w_shamt;
         OP_SRL:  w_result = w_data >> w_shamt;
         OP_SRA:  w_result = XLEN'($signed(w_data) >>> w_shamt);
         default: w_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_id    <= 1'b0;
         r_err   <= 1'b0;
         r_ptr   <= 1'b0;
      end else if (w_xfer) begin
         r_valid <= 1'b1;
         r_data  <= w_result;
         r_id    <= w_sel;
         r_err   <= w_illegal;
         r_ptr   <= ~w_sel;
      end else if (rsp_ready_i) begin
         r_valid <= 1'b0;
      end
   end

   assign rsp_valid_o = r_valid;
   assign rsp_data_o  = r_data;
   assign rsp_id_o    = r_id;
   assign rsp_err_o   = r_err;
endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed-vector bench for shift_arbiter
module tb_shift_arbiter;
   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_op;
   logic [63:0] req_data;
   logic [9:0]  req_shamt;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_id;
   logic        rsp_err;

   int n_vec;
   int n_err;

   shift_arbiter dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_op_i    (req_op),
      .req_data_i  (req_data),
      .req_shamt_i (req_shamt),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data),
      .rsp_id_o    (rsp_id),
      .rsp_err_o   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic set_port(input int p, input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
      req_op[p*2 +: 2]    = op;
      req_data[p*32 +: 32] = d;
      req_shamt[p*5 +: 5] = sh;
   endtask

   // Lone request on one port; inputs change at negedge, result checked one negedge later.
   task automatic single(input string tag, input int p, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] sh, input logic [31:0] exp_d, input logic exp_e);
      logic [1:0] exp_rdy;
      exp_rdy = (p == 1) ? 2'b10 : 2'b01;
      set_port(p, op, d, sh);
      req_valid = exp_rdy;
      #1;
      check_vec({tag, "_rdy"}, 64'(req_ready), 64'(exp_rdy));
      @(negedge clk);
      req_valid = 2'b00;
      check_vec({tag, "_vld"}, 64'(rsp_valid), 64'd1);
      check_vec({tag, "_data"}, 64'(rsp_data), 64'(exp_d));
      check_vec({tag, "_id"}, 64'(rsp_id), 64'(p));
      check_vec({tag, "_err"}, 64'(rsp_err), 64'(exp_e));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      req_valid = 2'b00;
      req_op = '0;
      req_data = '0;
      req_shamt = '0;
      rsp_ready = 1'b1;

      @(negedge clk);
      req_valid = 2'b11;
      #1;
      check_vec("rst_ready", 64'(req_ready), 64'd0);
      check_vec("rst_valid", 64'(rsp_valid), 64'd0);
      check_vec("rst_data", 64'(rsp_data), 64'd0);
      check_vec("rst_id", 64'(rsp_id), 64'd0);
      check_vec("rst_err", 64'(rsp_err), 64'd0);
      req_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;

      single("p0_srl31", 0, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0);
      single("p1_sra4", 1, 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0);

      // Contention: pointer is back on port 0, expect 0,1,0,1 with no bubbles.
      set_port(0, 2'b00, 32'h0000_0001, 5'd1);
      set_port(1, 2'b01, 32'h0000_0100, 5'd4);
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_vec($sformatf("cont_rdy%0d", i), 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
         @(negedge clk);
         check_vec($sformatf("cont_vld%0d", i), 64'(rsp_valid), 64'd1);
         check_vec($sformatf("cont_id%0d", i), 64'(rsp_id), 64'(i % 2));
         check_vec($sformatf("cont_data%0d", i), 64'(rsp_data), (i % 2 == 0) ? 64'h2 : 64'h10);
      end

      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_vec($sformatf("bp_rdy%0d", i), 64'(req_ready), 64'd0);
         check_vec($sformatf("bp_data%0d", i), 64'(rsp_data), 64'h10);
         check_vec($sformatf("bp_id%0d", i), 64'(rsp_id), 64'd1);
         check_vec($sformatf("bp_vld%0d", i), 64'(rsp_valid), 64'd1);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      check_vec("bp_release_rdy", 64'(req_ready), 64'd1);
      @(negedge clk);
      check_vec("bp_release_id", 64'(rsp_id), 64'd0);
      check_vec("bp_release_data", 64'(rsp_data), 64'h2);
      req_valid = 2'b00;

      single("sll0", 0, 2'b00, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, 1'b0);
      single("sll31", 0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
      single("sra31_pos", 0, 2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0);
      single("srl0", 0, 2'b01, 32'h8765_4321, 5'd0, 32'h8765_4321, 1'b0);
      single("sra31_neg", 1, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);

      // Pointer sits on port 0 here; the illegal op from port 0 must move it to port 1.
      single("illegal", 0, 2'b11, 32'h1234_5678, 5'd3, 32'h0000_0000, 1'b1);
      set_port(0, 2'b00, 32'h0000_0003, 5'd2);
      set_port(1, 2'b00, 32'h0000_0005, 5'd1);
      req_valid = 2'b11;
      #1;
      check_vec("post_ill_rdy", 64'(req_ready), 64'd2);
      @(negedge clk);
      check_vec("post_ill_id", 64'(rsp_id), 64'd1);
      check_vec("post_ill_data", 64'(rsp_data), 64'hA);
      check_vec("post_ill_err", 64'(rsp_err), 64'd0);

      // Reset mid-operation with a held result.
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      #1;
      check_vec("pre_rst_vld", 64'(rsp_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check_vec("mid_rst_vld", 64'(rsp_valid), 64'd0);
      check_vec("mid_rst_data", 64'(rsp_data), 64'd0);
      check_vec("mid_rst_rdy", 64'(req_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      req_valid = 2'b11;
      #1;
      check_vec("after_rst_rdy", 64'(req_ready), 64'd1);
      @(negedge clk);
      check_vec("after_rst_id", 64'(rsp_id), 64'd0);
      check_vec("after_rst_data", 64'(rsp_data), 64'hC);
      req_valid = 2'b00;
      @(negedge clk);
      check_vec("drain_vld", 64'(rsp_valid), 64'd0);
      check_vec("drain_data_hold", 64'(rsp_data), 64'hC);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
